// File: rtl/wb_sdram_arb_if.sv
// wb_sdram_arb_if
//   Bundles the Wishbone signals around the two-master SDRAM arbiter:
//   master 0 and master 1 request ports (mN_*) and the single downstream
//   port to the SDRAM controller (s_*). Signal names keep their legacy
//   _i/_o suffixes as seen from the arbiter.
//   Modports:
//     slave  - arbiter side (takes mN_* requests, drives s_* to the controller)
//     master - environment side (drives mN_* requests, models the controller)
//   Parameters: AW address width, DW data width (byte selects are DW/8).
interface wb_sdram_arb_if #(
  parameter int unsigned AW = 26,
  parameter int unsigned DW = 32
);
  // master 0
  logic            m0_cyc_i;
  logic            m0_stb_i;
  logic            m0_we_i;
  logic [AW-1:0]   m0_adr_i;
  logic [DW-1:0]   m0_dat_i;
  logic [DW/8-1:0] m0_sel_i;
  logic            m0_ack_o;
  logic            m0_err_o;
  logic [DW-1:0]   m0_dat_o;
  // master 1
  logic            m1_cyc_i;
  logic            m1_stb_i;
  logic            m1_we_i;
  logic [AW-1:0]   m1_adr_i;
  logic [DW-1:0]   m1_dat_i;
  logic [DW/8-1:0] m1_sel_i;
  logic            m1_ack_o;
  logic            m1_err_o;
  logic [DW-1:0]   m1_dat_o;
  // SDRAM controller slave port
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW/8-1:0] s_sel_o;
  logic            s_ack_i;
  logic [DW-1:0]   s_dat_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/wb_sdram_arb.sv
// wb_sdram_arb
//   Two-master Wishbone arbiter in front of one SDRAM controller port.
//   Round-robin on ties (master 0 wins the first tie after reset), the grant
//   is held for the whole cycle (cyc) so bursts/RMW are never split, and an
//   8-bit ack watchdog aborts a stalled cycle with a one-clock err pulse.
//   Ports:
//     wb_clk_i  - clock, all logic on the rising edge
//     wb_rst_i  - synchronous active-high reset
//     bus       - wb_sdram_arb_if.slave: mN_* master ports, s_* controller port
//   Parameters: AW, DW (must match the interface), TO_CYCLES watchdog limit
//   in stalled clocks (1..255).
module wb_sdram_arb #(
  parameter int unsigned AW        = 26,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_sdram_arb_if.slave      bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  // Expiry fires on the clock where the stall count would reach TO_CYCLES,
  // i.e. the TO_CYCLES-th consecutive stalled clock.
  localparam logic [7:0] TO_LIM = 8'(TO_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [7:0]      wdt_q, wdt_d;

  logic            req0, req1;
  logic            gnt0, gnt1;
  logic            m_cyc, m_stb, expire;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat;
  logic [DW/8-1:0] s_sel;

  always_comb begin
    req0 = bus.m0_cyc_i & bus.m0_stb_i;
    req1 = bus.m1_cyc_i & bus.m1_stb_i;
    // Gating with reset drops the downstream port while reset is asserted.
    gnt0 = (state_q == GNT0) & ~wb_rst_i;
    gnt1 = (state_q == GNT1) & ~wb_rst_i;

    m_cyc = 1'b0;
    m_stb = 1'b0;
    s_we  = 1'b0;
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    if (gnt0) begin
      m_cyc = bus.m0_cyc_i;
      m_stb = bus.m0_stb_i;
      s_we  = bus.m0_we_i;
      s_adr = bus.m0_adr_i;
      s_dat = bus.m0_dat_i;
      s_sel = bus.m0_sel_i;
    end else if (gnt1) begin
      m_cyc = bus.m1_cyc_i;
      m_stb = bus.m1_stb_i;
      s_we  = bus.m1_we_i;
      s_adr = bus.m1_adr_i;
      s_dat = bus.m1_dat_i;
      s_sel = bus.m1_sel_i;
    end

    // A same-clock ack beats the watchdog, so expiry requires no ack.
    expire = m_stb & ~bus.s_ack_i & (wdt_q >= TO_LIM);
    s_cyc  = m_cyc & ~expire;
    s_stb  = m_stb & ~expire;
  end

  always_comb begin
    bus.s_cyc_o  = s_cyc;
    bus.s_stb_o  = s_stb;
    bus.s_we_o   = s_we;
    bus.s_adr_o  = s_adr;
    bus.s_dat_o  = s_dat;
    bus.s_sel_o  = s_sel;
    bus.m0_ack_o = gnt0 & bus.s_ack_i;
    bus.m1_ack_o = gnt1 & bus.s_ack_i;
    bus.m0_err_o = gnt0 & expire;
    bus.m1_err_o = gnt1 & expire;
    bus.m0_dat_o = bus.s_dat_i;
    bus.m1_dat_o = bus.s_dat_i;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: if (expire || !bus.m0_cyc_i) state_d = IDLE;
      GNT1: if (expire || !bus.m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stall counter: IDLE has s_stb low, so it is already clear on entry
    // to a grant; it saturates rather than wrapping.
    wdt_d = wdt_q;
    if (bus.s_ack_i || !s_stb) begin
      wdt_d = '0;
    end else if (wdt_q != 8'hFF) begin
      wdt_d = wdt_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdt_q   <= wdt_d;
    end
  end

endmodule
